adder: RTL and testbench

//   Parameterised two's-complement adder/subtractor: S = A + B (M=0) or S = A - B (M=1).

---
 rtl/adder.sv | 55 +++++
 tb/tb_adder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/adder.sv
// ============================================================================
// adder: ripple-carry two's-complement adder/subtractor, combinational result
// and flags, plus a registered copy of {V,Cout,Z,N}.  Revision 1.0
// ============================================================================
`default_nettype none

module adder #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             M,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             V,
   output logic             Z,
   output logic             N,
   output logic [3:0]       flags_q
);

   logic [WIDTH-1:0] bx;

   assign bx = B ^ {WIDTH{M}};

   // Carries live inside each cell so the chain is a set of scalar nets
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      logic ci;
      logic co;
      if (i == 0) begin : g_lsb
         assign ci = M;
      end else begin : g_chain
         assign ci = g_fa[i-1].co;
      end
      assign S[i] = A[i] ^ bx[i] ^ ci;
      assign co   = (A[i] & bx[i]) | (ci & (A[i] ^ bx[i]));
   end

   assign Cout = g_fa[WIDTH-1].co;
   assign V    = g_fa[WIDTH-1].co ^ g_fa[WIDTH-1].ci;
   assign Z    = ~|S;
   assign N    = S[WIDTH-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= 4'b0000;
      end else begin
         flags_q <= {V, Cout, Z, N};
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_adder.sv
// ============================================================================
// tb_adder: directed and random checks of adder against an arithmetic model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_adder;

   localparam int W = 64;

   logic          clk;
   logic          rst;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          M;
   logic [W-1:0]  S;
   logic          Cout;
   logic          V;
   logic          Z;
   logic          N;
   logic [3:0]    flags_q;

   int checks;
   int failures;

   adder #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .A       (A),
      .B       (B),
      .M       (M),
      .S       (S),
      .Cout    (Cout),
      .V       (V),
      .Z       (Z),
      .N       (N),
      .flags_q (flags_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference: unsigned/signed arithmetic on the operands themselves
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                                 output logic [W-1:0] s, output logic [3:0] fl);
      logic [W:0] wide;
      logic       cout, v, z, n;
      if (m) begin
         s    = a - b;
         cout = (a >= b);
         v    = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
      end else begin
         wide = {1'b0, a} + {1'b0, b};
         s    = wide[W-1:0];
         cout = wide[W];
         v    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      z  = (s == '0);
      n  = s[W-1];
      fl = {v, cout, z, n};
   endfunction

   task automatic apply(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic m, input logic r);
      logic [W-1:0] es;
      logic [3:0]   ef;
      @(negedge clk);
      A = a; B = b; M = m; rst = r;
      #1;
      model(a, b, m, es, ef);
      check({tag, ".S"}, S, es);
      check({tag, ".flags"}, {60'd0, V, Cout, Z, N}, {60'd0, ef});
      @(posedge clk);
      #1;
      check({tag, ".flags_q"}, {60'd0, flags_q}, r ? '0 : {60'd0, ef});
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rm;
      checks = 0; failures = 0;
      rst = 1'b1; A = '0; B = '0; M = 1'b0;
      @(posedge clk); #1;
      check("reset.flags_q", {60'd0, flags_q}, '0);

      // Directed cases with literal expectations
      @(negedge clk); rst = 1'b0; A = 64'h1000; B = 64'd4; M = 1'b0; #1;
      check("pc4.S", S, 64'h1004);
      check("pc4.flags", {60'd0, V, Cout, Z, N}, {60'd0, 4'b0000});
      @(negedge clk); A = '1; B = 64'd1; M = 1'b0; #1;
      check("wrap.S", S, '0);
      check("wrap.flags", {60'd0, V, Cout, Z, N}, {60'd0, 4'b0110});
      @(negedge clk); A = 64'h7FFF_FFFF_FFFF_FFFF; B = 64'd1; M = 1'b0; #1;
      check("maxpos1.S", S, 64'h8000_0000_0000_0000);
      check("maxpos1.flags", {60'd0, V, Cout, Z, N}, {60'd0, 4'b1001});
      @(negedge clk); A = 64'd5; B = 64'd7; M = 1'b1; #1;
      check("5m7.S", S, 64'hFFFF_FFFF_FFFF_FFFE);
      check("5m7.flags", {60'd0, V, Cout, Z, N}, {60'd0, 4'b0001});
      @(negedge clk); A = 64'd7; B = 64'd5; M = 1'b1; #1;
      check("7m5.S", S, 64'd2);
      check("7m5.flags", {60'd0, V, Cout, Z, N}, {60'd0, 4'b0100});
      @(negedge clk); A = 64'h1234; B = 64'h1234; M = 1'b1; #1;
      check("aa.S", S, '0);
      check("aa.flags", {60'd0, V, Cout, Z, N}, {60'd0, 4'b0110});
      @(posedge clk); #1;
      check("aa.flags_q", {60'd0, flags_q}, {60'd0, 4'b0110});
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("aa.rst.flags_q", {60'd0, flags_q}, '0);
      check("aa.rst.S", S, '0);
      @(negedge clk); rst = 1'b0; A = '0; B = 64'd1; M = 1'b1; #1;
      check("0m1.S", S, '1);
      check("0m1.flags", {60'd0, V, Cout, Z, N}, {60'd0, 4'b0001});
      @(negedge clk); A = 64'h8000_0000_0000_0000; B = 64'd1; M = 1'b1; #1;
      check("minneg1.S", S, 64'h7FFF_FFFF_FFFF_FFFF);
      check("minneg1.flags", {60'd0, V, Cout, Z, N}, {60'd0, 4'b1100});
      // Mode flip alone changes the result
      @(negedge clk); A = 64'd10; B = 64'd3; M = 1'b0; #1;
      check("modeadd.S", S, 64'd13);
      M = 1'b1; #1;
      check("modesub.S", S, 64'd7);

      apply("pipe0", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
      apply("pipe1", 64'h0123, 64'h0456, 1'b1, 1'b0);

      for (int i = 0; i < 10000; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rm = $urandom_range(0, 1) == 1;
         case ($urandom_range(0, 7))
            0: rb = ra;
            1: ra = {1'b0, {(W-1){1'b1}}};
            2: ra = {1'b1, {(W-1){1'b0}}};
            3: rb = '1;
            default: ;
         endcase
         apply("rand", ra, rb, rm, ($urandom_range(0, 63) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
